// File: rtl/csi2_rx_pkg.sv
// ============================================================================
// csi2_rx_pkg : shared types and default widths for the CSI-2 receive path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package csi2_rx_pkg;

    localparam int CROP_DATA_WIDTH_DEF = 16;
    localparam int CROP_X_WIDTH_DEF    = 12;
    localparam int CROP_Y_WIDTH_DEF    = 12;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DONE     = 2'd2
    } crop_state_t;

endpackage

`default_nettype wire

// File: rtl/axi4_stream_skid_buf.sv
// ============================================================================
// axi4_stream_skid_buf : 2-entry registered AXI4-Stream buffer, full throughput.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module axi4_stream_skid_buf #(
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        push         = s_valid_i && ready_q;
        pop          = out_valid_q && m_ready_i;
        // The skid slot is only ever filled while the output slot is stalled.
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_data_d = s_data_i;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

`default_nettype wire

// File: rtl/csi2_video_crop.sv
// ============================================================================
// csi2_video_crop : crops a window from the CSI-2 pixel stream, SOF-latched CSRs.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module csi2_video_crop
    import csi2_rx_pkg::*;
#(
    parameter int DATA_WIDTH = CROP_DATA_WIDTH_DEF,
    parameter int X_WIDTH    = CROP_X_WIDTH_DEF,
    parameter int Y_WIDTH    = CROP_Y_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [X_WIDTH-1:0]    crop_x0_i,
    input  logic [Y_WIDTH-1:0]    crop_y0_i,
    input  logic [X_WIDTH-1:0]    crop_width_i,
    input  logic [Y_WIDTH-1:0]    crop_height_i,
    input  logic [DATA_WIDTH-1:0] video_i_tdata,
    input  logic                  video_i_tvalid,
    input  logic                  video_i_tuser,
    input  logic                  video_i_tlast,
    output logic                  video_i_tready,
    output logic [DATA_WIDTH-1:0] video_o_tdata,
    output logic                  video_o_tvalid,
    output logic                  video_o_tuser,
    output logic                  video_o_tlast,
    input  logic                  video_o_tready,
    output logic                  line_err_o,
    output logic                  frame_done_o
);

    localparam int SKW = DATA_WIDTH + 2;

    crop_state_t          state_q, state_d;
    logic [X_WIDTH-1:0]   x_q, x_d, x0_q, x0_d;
    logic [Y_WIDTH-1:0]   y_q, y_d, y0_q, y0_d;
    logic [X_WIDTH:0]     xend_q, xend_d;
    logic [Y_WIDTH:0]     yend_q, yend_d;
    logic                 first_q, first_d;
    logic                 line_err_q, line_err_d;
    logic                 frame_done_q, frame_done_d;

    logic [X_WIDTH-1:0]   cur_x, cur_x0;
    logic [Y_WIDTH-1:0]   cur_y, cur_y0;
    logic [X_WIDTH:0]     cur_xend;
    logic [Y_WIDTH:0]     cur_yend;
    logic                 cur_first, cur_active;
    logic                 last_col, last_row, in_win, beat;
    logic                 skid_ready;
    logic [SKW-1:0]       skid_in, skid_out;

    assign beat = video_i_tvalid && skid_ready;

    // A tuser beat is itself pixel (0,0) of the new frame, so its own
    // evaluation uses the freshly sampled window rather than the registers.
    always_comb begin
        cur_x      = video_i_tuser ? '0 : x_q;
        cur_y      = video_i_tuser ? '0 : y_q;
        cur_x0     = video_i_tuser ? crop_x0_i : x0_q;
        cur_y0     = video_i_tuser ? crop_y0_i : y0_q;
        cur_xend   = video_i_tuser ? ({1'b0, crop_x0_i} + {1'b0, crop_width_i}) : xend_q;
        cur_yend   = video_i_tuser ? ({1'b0, crop_y0_i} + {1'b0, crop_height_i}) : yend_q;
        cur_first  = video_i_tuser ? 1'b1 : first_q;
        cur_active = video_i_tuser || (state_q == ACTIVE);
        last_col   = ({1'b0, cur_x} + (X_WIDTH+1)'(1)) == cur_xend;
        last_row   = ({1'b0, cur_y} + (Y_WIDTH+1)'(1)) == cur_yend;
        in_win     = cur_active
                  && (cur_x >= cur_x0) && ({1'b0, cur_x} < cur_xend)
                  && (cur_y >= cur_y0) && ({1'b0, cur_y} < cur_yend);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        xend_d       = xend_q;
        yend_d       = yend_q;
        first_d      = first_q;
        line_err_d   = 1'b0;
        frame_done_d = 1'b0;
        if (beat) begin
            x0_d    = cur_x0;
            y0_d    = cur_y0;
            xend_d  = cur_xend;
            yend_d  = cur_yend;
            first_d = cur_first && !in_win;
            if (video_i_tlast) begin
                x_d = '0;
                y_d = (&cur_y) ? cur_y : cur_y + Y_WIDTH'(1);
            end else begin
                x_d = (&cur_x) ? cur_x : cur_x + X_WIDTH'(1);
                y_d = cur_y;
            end
            if (cur_active) begin
                state_d = ACTIVE;
            end
            line_err_d   = in_win && video_i_tlast && !last_col;
            frame_done_d = in_win && last_col && last_row;
            if (frame_done_d) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            xend_q       <= '0;
            yend_q       <= '0;
            first_q      <= 1'b0;
            line_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            xend_q       <= xend_d;
            yend_q       <= yend_d;
            first_q      <= first_d;
            line_err_q   <= line_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign skid_in = {cur_first, (last_col || video_i_tlast), video_i_tdata};

    axi4_stream_skid_buf #(
        .WIDTH (SKW)
    ) u_skid (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .s_valid_i (video_i_tvalid && in_win),
        .s_ready_o (skid_ready),
        .s_data_i  (skid_in),
        .m_valid_o (video_o_tvalid),
        .m_ready_i (video_o_tready),
        .m_data_o  (skid_out)
    );

    assign video_i_tready = skid_ready;
    assign video_o_tuser  = skid_out[SKW-1];
    assign video_o_tlast  = skid_out[SKW-2];
    assign video_o_tdata  = skid_out[DATA_WIDTH-1:0];
    assign line_err_o     = line_err_q;
    assign frame_done_o   = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_csi2_video_crop.sv
// ============================================================================
// tb_csi2_video_crop : scoreboard bench for csi2_video_crop.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_csi2_video_crop;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [11:0] x0, y0, wd, ht;
    logic [15:0] vi_tdata;
    logic        vi_tvalid, vi_tuser, vi_tlast, vi_tready;
    logic [15:0] vo_tdata;
    logic        vo_tvalid, vo_tuser, vo_tlast, vo_tready;
    logic        line_err, frame_done;

    typedef struct packed {
        logic [15:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    n_err_pulse = 0;
    int    n_done_pulse = 0;
    int    n_rdy_low = 0;
    int    rdy_mode = 0;

    always #5 clk = ~clk;

    csi2_video_crop dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .crop_x0_i      (x0),
        .crop_y0_i      (y0),
        .crop_width_i   (wd),
        .crop_height_i  (ht),
        .video_i_tdata  (vi_tdata),
        .video_i_tvalid (vi_tvalid),
        .video_i_tuser  (vi_tuser),
        .video_i_tlast  (vi_tlast),
        .video_i_tready (vi_tready),
        .video_o_tdata  (vo_tdata),
        .video_o_tvalid (vo_tvalid),
        .video_o_tuser  (vo_tuser),
        .video_o_tlast  (vo_tlast),
        .video_o_tready (vo_tready),
        .line_err_o     (line_err),
        .frame_done_o   (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output ready pattern: 0 = always ready, 1 = random 50%, 2 = stalled.
    always @(negedge clk) begin
        if (rdy_mode == 0)      vo_tready = 1'b1;
        else if (rdy_mode == 1) vo_tready = 1'($urandom_range(0, 1));
        else                    vo_tready = 1'b0;
    end

    // Monitor: samples mid-cycle, ahead of the rising edge that commits the handshake.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #3;
            if (arst_n) begin
                if (line_err)   n_err_pulse++;
                if (frame_done) n_done_pulse++;
                if (!vi_tready) begin
                    n_rdy_low++;
                    chk("ready_low_implies_out_valid", 32'(vo_tvalid), 32'd1);
                end
                if (vo_tvalid && vo_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got tdata=0x%0h tuser=%0d tlast=%0d expected no beat",
                                 vo_tdata, vo_tuser, vo_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", 32'(vo_tdata), 32'(e.d));
                        chk("tuser", 32'(vo_tuser), 32'(e.u));
                        chk("tlast", 32'(vo_tlast), 32'(e.l));
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic u, input logic l);
        int n = 0;
        bit ok = 0;
        vi_tdata  = d;
        vi_tuser  = u;
        vi_tlast  = l;
        vi_tvalid = 1'b1;
        do begin
            #3;
            ok = vi_tready;
            @(negedge clk);
            n++;
        end while (!ok && n < 100);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL input_stall: got tready=0 for %0d cycles expected acceptance", n);
        end
        vi_tvalid = 1'b0;
        vi_tuser  = 1'b0;
        vi_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] tag, input int rows, input int cols,
                              input int nbeats, input bit junk);
        int idx = 0;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                if (idx < nbeats) begin
                    send(tag | 16'(y << 8) | 16'(x), idx == 0, x == cols - 1);
                    if (idx == 0 && junk) begin
                        x0 = 12'd0; y0 = 12'd0; wd = 12'd8; ht = 12'd4;
                    end
                end
                idx++;
            end
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d;
        b.u = u;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // Regular window: rows y0.., cols x0.., tlast on the window edge or the line end.
    task automatic expect_win(input logic [15:0] tag, input int cx0, input int cy0,
                              input int cw, input int ch, input int cols, input int rows);
        bit first = 1;
        for (int y = cy0; y < cy0 + ch && y < rows; y++) begin
            for (int x = cx0; x < cx0 + cw && x < cols; x++) begin
                push_exp(tag | 16'(y << 8) | 16'(x), first, (x == cx0 + cw - 1) || (x == cols - 1));
                first = 0;
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_o_tvalid"}, 32'(vo_tvalid), 32'd0);
        chk({tag, "_o_tdata"},  32'(vo_tdata),  32'd0);
        chk({tag, "_o_tuser"},  32'(vo_tuser),  32'd0);
        chk({tag, "_o_tlast"},  32'(vo_tlast),  32'd0);
        chk({tag, "_i_tready"}, 32'(vi_tready), 32'd1);
        chk({tag, "_line_err"}, 32'(line_err),  32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, d0, r0;
        vi_tdata = '0; vi_tvalid = 0; vi_tuser = 0; vi_tlast = 0; vo_tready = 1;
        x0 = '0; y0 = '0; wd = '0; ht = '0;
        repeat (2) @(negedge clk);
        #3;
        chk_reset_outputs("rst");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // A: 8x4 frame, window (2,1) 4x2, CSRs scrambled after SOF.
        x0 = 12'd2; y0 = 12'd1; wd = 12'd4; ht = 12'd2;
        e0 = n_err_pulse; d0 = n_done_pulse; r0 = n_rdy_low;
        expect_win(16'h1000, 2, 1, 4, 2, 8, 4);
        send_frame(16'h1000, 4, 8, 32, 1);
        drain("A_drain");
        chk("A_frame_done", 32'(n_done_pulse - d0), 32'd1);
        chk("A_line_err",   32'(n_err_pulse - e0),  32'd0);
        chk("A_ready_low",  32'(n_rdy_low - r0),    32'd0);

        // B: same frame, random output backpressure.
        x0 = 12'd2; y0 = 12'd1; wd = 12'd4; ht = 12'd2;
        rdy_mode = 1;
        d0 = n_done_pulse;
        expect_win(16'h2000, 2, 1, 4, 2, 8, 4);
        send_frame(16'h2000, 4, 8, 32, 0);
        drain("B_drain");
        rdy_mode = 0;
        chk("B_frame_done", 32'(n_done_pulse - d0), 32'd1);

        // C: window runs past the line end: short lines flagged.
        x0 = 12'd4; y0 = 12'd0; wd = 12'd6; ht = 12'd2;
        e0 = n_err_pulse; d0 = n_done_pulse;
        expect_win(16'h3000, 4, 0, 6, 2, 8, 3);
        send_frame(16'h3000, 3, 8, 24, 0);
        drain("C_drain");
        chk("C_line_err",   32'(n_err_pulse - e0),  32'd2);
        chk("C_frame_done", 32'(n_done_pulse - d0), 32'd0);

        // D: zero width keeps nothing.
        x0 = 12'd0; y0 = 12'd0; wd = 12'd0; ht = 12'd4;
        r0 = n_rdy_low; d0 = n_done_pulse;
        send_frame(16'h4000, 4, 8, 32, 0);
        drain("D_drain");
        chk("D_ready_low",  32'(n_rdy_low - r0),    32'd0);
        chk("D_out_valid",  32'(vo_tvalid),         32'd0);
        chk("D_frame_done", 32'(n_done_pulse - d0), 32'd0);

        // E: SOF arrives at pixel 13 with a new window.
        x0 = 12'd2; y0 = 12'd1; wd = 12'd4; ht = 12'd2;
        e0 = n_err_pulse; d0 = n_done_pulse;
        push_exp(16'h5102, 1'b1, 1'b0);
        push_exp(16'h5103, 1'b0, 1'b0);
        push_exp(16'h5104, 1'b0, 1'b0);
        send_frame(16'h5000, 4, 8, 13, 0);
        x0 = 12'd1; y0 = 12'd2; wd = 12'd3; ht = 12'd1;
        expect_win(16'h6000, 1, 2, 3, 1, 8, 4);
        send_frame(16'h6000, 4, 8, 32, 0);
        drain("E_drain");
        chk("E_frame_done", 32'(n_done_pulse - d0), 32'd1);
        chk("E_line_err",   32'(n_err_pulse - e0),  32'd0);

        // F: reset with both buffer entries occupied.
        x0 = 12'd2; y0 = 12'd1; wd = 12'd4; ht = 12'd2;
        rdy_mode = 2;
        send_frame(16'h7000, 4, 8, 12, 0);
        #3;
        chk("F_full_ready", 32'(vi_tready), 32'd0);
        chk("F_full_valid", 32'(vo_tvalid), 32'd1);
        @(negedge clk);
        arst_n = 1'b0;
        #3;
        chk_reset_outputs("F_rst");
        @(negedge clk);
        rdy_mode = 0;
        arst_n = 1'b1;
        @(negedge clk);
        x0 = 12'd0; y0 = 12'd0; wd = 12'd2; ht = 12'd1;
        for (int i = 0; i < 5; i++) send(16'h7800 | 16'(i), 1'b0, i == 4);
        d0 = n_done_pulse;
        push_exp(16'h9000, 1'b1, 1'b0);
        push_exp(16'h9001, 1'b0, 1'b1);
        send_frame(16'h9000, 2, 4, 8, 0);
        drain("F_drain");
        chk("F_frame_done", 32'(n_done_pulse - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
